// File: rtl/mem_dcache_seq.sv
// MEM-stage load/store sequencer: stalls the pipeline around one bus req/ack beat; optional abort via DCACHE_TIMEOUT_EN.
// Accept-to-ready is 2 cycles minimum; bus_req is held until bus_ack (or timeout), and the stall is held for the whole transaction.

`ifndef CTRL_Wire_Bus
`define CTRL_Wire_Bus 2:0
`endif
`ifndef CTRL_STATE_Normal
`define CTRL_STATE_Normal 3'd0
`endif
`ifndef CTRL_STATE_Bubble
`define CTRL_STATE_Bubble 3'd1
`endif
`ifndef CTRL_STATE_Block
`define CTRL_STATE_Block 3'd2
`endif
`ifndef CTRL_STATE_Branch
`define CTRL_STATE_Branch 3'd3
`endif

module mem_dcache_seq #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_req_valid_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_W-1:0]      mem_pc_i,
  input  logic [ADDR_W-1:0]      mem_addr_i,
  input  logic [DATA_W-1:0]      mem_wdata_i,
  input  logic [DATA_W/8-1:0]    mem_wmask_i,
  input  logic [`CTRL_Wire_Bus]  ctrl_signal_dcache_i,
  output logic                   mem_block_flag_o,
  output logic                   dcache_ready_o,
  output logic [DATA_W-1:0]      mem_rdata_o,
  output logic                   dcache_err_o,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [ADDR_W-1:0]      bus_addr_o,
  output logic [DATA_W-1:0]      bus_wdata_o,
  output logic [DATA_W/8-1:0]    bus_wmask_o,
  input  logic                   bus_ack_i,
  input  logic [DATA_W-1:0]      bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                served;
  logic [ADDR_W-1:0]   served_pc;
  logic [ADDR_W-1:0]   pc_q;
  logic                accept;
  logic                timeout_hit;

  // The served/served_pc pair stops a still-frozen instruction from being issued twice.
  assign accept = mem_req_valid_i
               && (ctrl_signal_dcache_i != `CTRL_STATE_Bubble)
               && !(served && (mem_pc_i == served_pc));

`ifdef DCACHE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] to_cnt;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      to_cnt <= (state == REQ) ? to_cnt + 1'b1 : '0;
      err_q  <= timeout_hit;
    end
  end

  // An ack arriving in the last allowed cycle still wins over the timeout.
  assign timeout_hit  = (state == REQ) && !bus_ack_i && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign dcache_err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign timeout_hit    = 1'b0;
  assign dcache_err_o   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    mem_block_flag_o = 1'b0;
    bus_req_o        = 1'b0;
    dcache_ready_o   = 1'b0;
    case (state)
      IDLE: begin
        mem_block_flag_o = accept;
        if (accept) state_nxt = REQ;
      end
      REQ: begin
        mem_block_flag_o = 1'b1;
        bus_req_o        = 1'b1;
        if (bus_ack_i || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        dcache_ready_o = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wmask_o <= '0;
      pc_q        <= '0;
      mem_rdata_o <= '0;
      served      <= 1'b0;
      served_pc   <= '0;
    end else begin
      if ((state == IDLE) && accept) begin
        bus_we_o    <= mem_we_i;
        bus_addr_o  <= mem_addr_i;
        bus_wdata_o <= mem_wdata_i;
        bus_wmask_o <= mem_we_i ? mem_wmask_i : '0;
        pc_q        <= mem_pc_i;
      end
      if (state == REQ) begin
        if (bus_ack_i)        mem_rdata_o <= bus_we_o ? '0 : bus_rdata_i;
        else if (timeout_hit) mem_rdata_o <= '1;
      end
      if (state == DONE) begin
        served    <= 1'b1;
        served_pc <= pc_q;
      end
      if ((state == IDLE) && !mem_req_valid_i) served <= 1'b0;
    end
  end

endmodule

// File: doc/mem_dcache_seq.md
# mem_dcache_seq

MEM-stage data-access sequencer: the responder side of the pipeline controller's stall protocol. It accepts one load/store per instruction from the MEM stage, raises `mem_block_flag_o` to freeze the pipeline, and runs a single-beat request/acknowledge transaction on the data bus. It then pulses `dcache_ready_o` with the load data so the controller releases the stall. It sits between the MEM stage, the CTRL block and the memory bus.

## Interface
- `ADDR_W`, 64, address width (matches `AddrBus`)
- `DATA_W`, 64, data width; multiple of 8
- `TIMEOUT_CYC`, 256, bus-wait limit in cycles (used only with `DCACHE_TIMEOUT_EN`)

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `mem_req_valid_i`  in  1  MEM stage holds a load/store
- `mem_we_i`  in  1  1 = store, 0 = load
- `mem_pc_i`  in  ADDR_W  PC of the requesting instruction
- `mem_addr_i`  in  ADDR_W  access address
- `mem_wdata_i`  in  DATA_W  store data
- `mem_wmask_i`  in  DATA_W/8  store byte enables
- `ctrl_signal_dcache_i`  in  `CTRL_Wire_Bus`  controller command (`CTRL_STATE_*`)
- `mem_block_flag_o`  out  1  stall request to CTRL
- `dcache_ready_o`  out  1  one-cycle completion pulse to CTRL
- `mem_rdata_o`  out  DATA_W  load data, valid while `dcache_ready_o`=1
- `dcache_err_o`  out  1  timeout abort flag, coincident with `dcache_ready_o`
- `bus_req_o`  out  1  bus request
- `bus_we_o`, `bus_addr_o`, `bus_wdata_o`, `bus_wmask_o`  out  1/ADDR_W/DATA_W/DATA_W/8  registered request payload
- `bus_ack_i`  in  1  bus completion
- `bus_rdata_i`  in  DATA_W  read data, valid with `bus_ack_i`

## Operation
- **States:** IDLE, REQ, DONE.
- **Acceptance (IDLE):** a request is accepted when all of the following hold:
  - `mem_req_valid_i`=1
  - `ctrl_signal_dcache_i` ≠ `CTRL_STATE_Bubble`
  - not (`served`=1 and `mem_pc_i`==`served_pc`)
- **On accept:**
  - Latch we/addr/wdata/wmask into the bus payload registers.
  - Go to REQ.
- **`mem_block_flag_o`:**
  - Combinational in IDLE: equals the acceptance term, so CTRL sees the stall in the request cycle.
  - Forced to 1 in REQ.
  - Forced to 0 in DONE.
- **REQ:**
  - `bus_req_o`=1 and the payload is held stable.
  - `bus_ack_i` is sampled only in REQ.
  - On ack: capture `bus_rdata_i` into `mem_rdata_o` (stores capture 0), then go to DONE.
- **DONE:**
  - `dcache_ready_o`=1 for exactly one cycle.
  - Set `served`=1 and `served_pc`=latched PC.
  - Go to IDLE.
- **`served` clear:** cleared in any IDLE cycle with `mem_req_valid_i`=0. This prevents re-issuing the same instruction while the pipeline is still frozen.
- **Controller commands in REQ/DONE:** `CTRL_STATE_Bubble`/`Block`/`Branch` do not abort; a started bus transaction always completes.
- **Write mask:** `bus_wmask_o`=0 on loads regardless of `mem_wmask_i`.

## Timing
- **Reset values (when `rst`=0 at an edge):**
  - State = IDLE.
  - All outputs 0: `bus_req_o`, `dcache_ready_o`, `dcache_err_o`, `mem_rdata_o`, bus payload.
  - `served`=0, `served_pc`=0.
  - A reset mid-REQ drops `bus_req_o` at that edge; no ready pulse is produced.
- **Cycle sequence:** request accepted in cycle T. `bus_req_o` is high from T+1. Ack sampled in cycle T+k (k≥1). `dcache_ready_o` is high in T+k+1. IDLE again at T+k+2.
- **Minimum latency:** accept to ready is 2 cycles (ack in the first REQ cycle).
- **Back-to-back accesses:** a new request with a different `mem_pc_i` may be accepted in T+k+2 (the first IDLE cycle).
- **Ack in IDLE/DONE:** ignored, with no state change.

## Configuration
- **`DCACHE_TIMEOUT_EN` defined:**
  - A counter runs in REQ.
  - After `TIMEOUT_CYC` REQ cycles without ack, go to DONE with `mem_rdata_o` = all ones and `dcache_err_o`=1.
  - `bus_req_o` drops on that transition.
- **`DCACHE_TIMEOUT_EN` undefined:**
  - No counter; REQ waits indefinitely.
  - `dcache_err_o` is tied to 0.

## Test plan
- **Load:** reset, then load addr 0x80000010 pc 0x80000000; ack after 3 REQ cycles with rdata 0x1122334455667788 -> block flag high T..T+3, `bus_req_o` high T+1..T+3, ready and rdata=0x1122334455667788 at T+4.
- **Store:** wmask 0x0F, wdata 0xDEADBEEF, ack in first REQ cycle -> bus_we=1, wmask=0x0F, ready at T+2, `mem_rdata_o`=0.
- **Held request:** `mem_req_valid_i` held with same pc after ready -> no second `bus_req_o`. Change pc to 0x80000004 -> new accept in the first IDLE cycle.
- **Bubble:** `ctrl_signal_dcache_i`=`CTRL_STATE_Bubble` with valid request in IDLE -> no accept, block flag 0. Bubble asserted during REQ -> transaction completes normally.
- **Reset mid-operation:** `rst`=0 in second REQ cycle -> next cycle `bus_req_o`=0, state IDLE, no ready pulse, late ack ignored.
- **Timeout (`DCACHE_TIMEOUT_EN`, TIMEOUT_CYC=4):** no ack -> after 4 REQ cycles ready=1, err=1, rdata=all ones.
